mgmt_gpio_ctrl: RTL and testbench

MGMT_GPIO_CTRL -- requirements
Module: mgmt_gpio_ctrl

---
 rtl/mgmt_gpio_ctrl.sv | 128 ++++++++++++
 tb/tb_mgmt_gpio_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_gpio_ctrl.sv
// mgmt_gpio_ctrl: Wishbone-managed GPIO pad with blink/pulse generator and edge interrupts
module mgmt_gpio_ctrl #(
  parameter logic RESET_OUT = 1'b0,
  parameter int   DIV_W     = 16
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        gpio_in_pad,
  output logic        gpio_out_pad,
  output logic        gpio_oeb,
  output logic        gpio_irq
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  state_t state, state_nxt;
  logic [5:0] ctrl, ctrl_nxt;
  logic [DIV_W-1:0] period, period_nxt, p_eff, cnt, cnt_nxt, p_lat, p_lat_nxt;
  logic [7:0] count, count_nxt, c_lat, c_lat_nxt, blinks, blinks_nxt, blinks_inc;
  logic pulse, pulse_nxt;
  logic req, wr, wr_ctrl, wr_per, wr_cnt, wr_stat, start, stop, busy;
  logic s_meta, s_sync, s_prev, rise, fall, pend_r, pend_f, clr_r, clr_f;
  logic [31:0] bmask, rdata;
  logic unused_bits;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign wr_ctrl = wr & (wb_adr_i[3:2] == 2'd0);
  assign wr_per = wr & (wb_adr_i[3:2] == 2'd1);
  assign wr_cnt = wr & (wb_adr_i[3:2] == 2'd2);
  assign wr_stat = wr & (wb_adr_i[3:2] == 2'd3);
  assign start = wr_ctrl & wb_sel_i[1] & wb_dat_i[8];
  assign stop = wr_ctrl & wb_sel_i[1] & wb_dat_i[9];
  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign ctrl_nxt = (wr_ctrl & wb_sel_i[0]) ? wb_dat_i[5:0] : ctrl;
  assign period_nxt = wr_per ? (period & ~bmask[DIV_W-1:0]) | (wb_dat_i[DIV_W-1:0] & bmask[DIV_W-1:0]) : period;
  assign count_nxt = (wr_cnt & wb_sel_i[0]) ? wb_dat_i[7:0] : count;
  assign p_eff = (period == '0) ? ONE : period;
  assign blinks_inc = blinks + 8'd1;
  assign busy = state != IDLE;
  assign rise = s_sync & ~s_prev;
  assign fall = ~s_sync & s_prev;
  assign clr_r = wr_stat & wb_sel_i[0] & wb_dat_i[2];
  assign clr_f = wr_stat & wb_sel_i[0] & wb_dat_i[3];
  assign gpio_oeb = ~ctrl[1];
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};
  assign rdata = (wb_adr_i[3:2] == 2'd0) ? {26'd0, ctrl} :
                 (wb_adr_i[3:2] == 2'd1) ? 32'(period) :
                 (wb_adr_i[3:2] == 2'd2) ? {24'd0, count} :
                 {28'd0, pend_f, pend_r, s_sync, busy};
  // Generator parameters are latched at start so register writes while busy only affect the next run
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    p_lat_nxt = p_lat;
    c_lat_nxt = c_lat;
    pulse_nxt = pulse;
    blinks_nxt = blinks;
    case (state)
      IDLE: if (start && (ctrl_nxt[3:2] == 2'b01 || ctrl_nxt[3:2] == 2'b10)) begin
        state_nxt = HIGH;
        cnt_nxt = p_eff;
        p_lat_nxt = p_eff;
        c_lat_nxt = count;
        pulse_nxt = ctrl_nxt[3];
        blinks_nxt = '0;
      end
      HIGH: if (cnt == ONE) begin
        state_nxt = pulse ? IDLE : LOW;
        cnt_nxt = p_lat;
      end else cnt_nxt = cnt - ONE;
      LOW: if (cnt == ONE) begin
        blinks_nxt = blinks_inc;
        state_nxt = (c_lat != 8'd0 && blinks_inc == c_lat) ? IDLE : HIGH;
        cnt_nxt = p_lat;
      end else cnt_nxt = cnt - ONE;
      default: state_nxt = IDLE;
    endcase
    if (stop) state_nxt = IDLE;
  end
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state <= IDLE;
      ctrl <= {5'd0, RESET_OUT};
      period <= '0;
      count <= '0;
      cnt <= '0;
      p_lat <= '0;
      c_lat <= '0;
      pulse <= 1'b0;
      blinks <= '0;
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
      pend_r <= 1'b0;
      pend_f <= 1'b0;
      gpio_out_pad <= RESET_OUT;
      gpio_irq <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      ctrl <= ctrl_nxt;
      period <= period_nxt;
      count <= count_nxt;
      cnt <= cnt_nxt;
      p_lat <= p_lat_nxt;
      c_lat <= c_lat_nxt;
      pulse <= pulse_nxt;
      blinks <= blinks_nxt;
      s_meta <= gpio_in_pad;
      s_sync <= s_meta;
      s_prev <= s_sync;
      pend_r <= rise | (pend_r & ~clr_r);
      pend_f <= fall | (pend_f & ~clr_f);
      gpio_out_pad <= (state_nxt == IDLE) ? ctrl_nxt[0] : (state_nxt == HIGH);
      gpio_irq <= (pend_r & ctrl[4]) | (pend_f & ctrl[5]);
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : 32'd0;
    end
  end
endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// tb_mgmt_gpio_ctrl: randomized bench for mgmt_gpio_ctrl against a timeline-based reference model
module tb_mgmt_gpio_ctrl;
  localparam logic RO = 1'b0;
  logic core_clk = 0, core_rstn = 0, cyc = 0, stb = 0, we = 0, pad = 0;
  logic [3:0] adr = 0, sel = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic ack, out, oeb, irq;
  int tests = 0, fails = 0;
  mgmt_gpio_ctrl #(.RESET_OUT(RO), .DIV_W(16)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .gpio_in_pad(pad), .gpio_out_pad(out), .gpio_oeb(oeb), .gpio_irq(irq)
  );
  always #5 core_clk = ~core_clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: generator output is a pure function of cycles elapsed since start
  int n, m_st, m_s, m_P, m_C, m_mode;
  logic m_ack, m_pr, m_pf, m_out, m_irq;
  logic [31:0] m_dat;
  logic [5:0] m_ctrl;
  logic [15:0] m_per;
  logic [7:0] m_cnt;
  logic [2:0] ph;
  logic t_req, t_wr, t_start, t_stop, t_rise, t_fall;
  logic [1:0] t_a;
  logic [5:0] t_ctrl;
  logic [31:0] t_rd;
  function automatic int seq_at(input int k);
    int half;
    if (m_mode == 2) return (k < m_P) ? 1 : 0;
    half = k / m_P;
    if (m_C != 0 && half >= 2 * m_C) return 0;
    return (half % 2 == 0) ? 1 : 2;
  endfunction
  always @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      n = 0; m_ack = 0; m_dat = 0; m_ctrl = {5'd0, RO}; m_per = 0; m_cnt = 0;
      m_pr = 0; m_pf = 0; m_out = RO; m_irq = 0; m_st = 0; m_s = 0; m_P = 1; m_C = 0; m_mode = 0; ph = 0;
    end else begin
      n++;
      t_req = cyc & stb & ~m_ack;
      t_wr = t_req & we;
      t_a = adr[3:2];
      t_rd = (t_a == 0) ? {26'd0, m_ctrl} : (t_a == 1) ? {16'd0, m_per} : (t_a == 2) ? {24'd0, m_cnt} :
             {28'd0, m_pf, m_pr, ph[1], 1'(m_st != 0)};
      t_ctrl = (t_wr && t_a == 0 && sel[0]) ? dat_i[5:0] : m_ctrl;
      t_start = t_wr && t_a == 0 && sel[1] && dat_i[8];
      t_stop = t_wr && t_a == 0 && sel[1] && dat_i[9];
      t_rise = ph[1] & ~ph[2];
      t_fall = ~ph[1] & ph[2];
      m_irq = (m_pr & m_ctrl[4]) | (m_pf & m_ctrl[5]);
      m_pr = t_rise | (m_pr & !(t_wr && t_a == 3 && sel[0] && dat_i[2]));
      m_pf = t_fall | (m_pf & !(t_wr && t_a == 3 && sel[0] && dat_i[3]));
      if (t_stop) m_st = 0;
      else if (m_st != 0) m_st = seq_at(n - m_s);
      else if (t_start && (t_ctrl[3:2] == 2'b01 || t_ctrl[3:2] == 2'b10)) begin
        m_s = n; m_P = (m_per == 0) ? 1 : int'(m_per); m_C = int'(m_cnt); m_mode = int'(t_ctrl[3:2]); m_st = 1;
      end
      m_out = (m_st == 0) ? t_ctrl[0] : (m_st == 1);
      if (t_wr && t_a == 1 && sel[0]) m_per[7:0] = dat_i[7:0];
      if (t_wr && t_a == 1 && sel[1]) m_per[15:8] = dat_i[15:8];
      if (t_wr && t_a == 2 && sel[0]) m_cnt = dat_i[7:0];
      m_ctrl = t_ctrl;
      m_dat = (t_req && !we) ? t_rd : 32'd0;
      m_ack = t_req;
      ph = {ph[1:0], pad};
    end
  end
  int hi_cnt = 0, rise_cnt = 0;
  logic prev_out = RO;
  always @(negedge core_clk) begin
    if (core_rstn) begin
      check("ack", ack, m_ack);
      check("dat_o", dat_o, m_dat);
      check("out", out, m_out);
      check("oeb", oeb, !m_ctrl[1]);
      check("irq", irq, m_irq);
      hi_cnt += int'(out);
      rise_cnt += int'(out & ~prev_out);
    end
    prev_out = out;
  end
  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; adr = a; dat_i = d; sel = s;
    @(posedge core_clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(posedge core_clk); #1;
  endtask
  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; adr = a;
    @(posedge core_clk); #1;
    d = dat_o;
    check("ack_hi", ack, 1);
    cyc = 0; stb = 0;
    @(posedge core_clk); #1;
    check("ack_lo", ack, 0);
  endtask
  task automatic cycles(input int k);
    repeat (k) @(posedge core_clk);
    #1;
  endtask
  logic [31:0] d;
  int h0, r0, op;
  initial begin
    #1;
    check("rst_out", out, RO);
    check("rst_oeb", oeb, 1);
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    check("rst_dat", dat_o, 0);
    cycles(2);
    core_rstn = 1;
    wb_read(4'h0, d); check("rd_ctrl_rst", d, {31'd0, RO});
    wb_read(4'h4, d); check("rd_per_rst", d, 0);
    wb_read(4'h8, d); check("rd_cnt_rst", d, 0);
    wb_read(4'hC, d); check("rd_stat_rst", d, 0);
    wb_write(4'h4, 4, 4'hF);
    wb_write(4'h8, 3, 4'hF);
    h0 = hi_cnt; r0 = rise_cnt;
    wb_write(4'h0, 32'h106, 4'h3);
    wb_read(4'hC, d); check("blink_busy", d, 1);
    cycles(25);
    check("blink_hi", hi_cnt - h0, 12);
    check("blink_rises", rise_cnt - r0, 3);
    check("blink_end_out", out, 0);
    wb_read(4'hC, d); check("blink_idle", d, 0);
    wb_write(4'h4, 0, 4'hF);
    wb_write(4'h8, 0, 4'hF);
    h0 = hi_cnt; r0 = rise_cnt;
    wb_write(4'h0, 32'h106, 4'h3);
    cycles(10);
    wb_write(4'h0, 32'h206, 4'h3);
    check("cont_hi", hi_cnt - h0, 6);
    check("cont_rises", rise_cnt - r0, 6);
    check("stop_out", out, 0);
    wb_read(4'hC, d); check("stop_idle", d, 0);
    wb_write(4'h4, 5, 4'hF);
    h0 = hi_cnt; r0 = rise_cnt;
    wb_write(4'h0, 32'h10A, 4'h3);
    wb_write(4'h0, 32'h10A, 4'h3);
    cycles(10);
    check("pulse_hi", hi_cnt - h0, 5);
    check("pulse_rises", rise_cnt - r0, 1);
    wb_write(4'h0, 32'h12, 4'h1);
    pad = 1; cycles(4);
    pad = 0; cycles(4);
    wb_read(4'hC, d); check("edge_stat", d, 32'hC);
    check("edge_irq", irq, 1);
    wb_write(4'hC, 32'h4, 4'h1);
    cycles(2);
    check("w1c_irq", irq, 0);
    wb_read(4'hC, d); check("w1c_stat", d, 32'h8);
    wb_write(4'h4, 4, 4'hF);
    wb_write(4'h8, 0, 4'hF);
    wb_write(4'h0, 32'h106, 4'h3);
    cycles(4);
    check("pre_rst_oeb", oeb, 0);
    #2 core_rstn = 0;
    #1;
    check("arst_out", out, RO);
    check("arst_oeb", oeb, 1);
    check("arst_ack", ack, 0);
    check("arst_irq", irq, 0);
    check("arst_dat", dat_o, 0);
    @(posedge core_clk); #1;
    core_rstn = 1;
    wb_write(4'h4, 32'hABCD, 4'h1);
    wb_read(4'h4, d); check("byte_wr", d, 32'hCD);
    wb_read(4'h0, d); check("ctrl_after_rst", d, {31'd0, RO});
    h0 = hi_cnt;
    cycles(10);
    check("no_resume", hi_cnt - h0, 0);
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) pad = ~pad;
      if (it == 200) begin
        #2 core_rstn = 0;
        @(posedge core_clk); #1;
        core_rstn = 1;
      end
      if (op <= 2) begin
        d = $urandom;
        d[9] = ($urandom_range(0, 5) == 0);
        wb_write({2'd0, 2'($urandom)}, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end else if (op == 3) wb_write({2'd1, 2'($urandom)}, $urandom & 32'hFFFF0003, 4'($urandom));
      else if (op == 4) wb_write({2'd2, 2'($urandom)}, $urandom & 32'hFFFFFF03, 4'($urandom));
      else if (op == 5) wb_write({2'd3, 2'($urandom)}, $urandom, 4'($urandom));
      else if (op <= 8) wb_read(4'($urandom), d);
      else pad = ~pad;
      cycles($urandom_range(0, 3));
    end
    cycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
